// File: rtl/acc_stream_loader.sv
// acc_stream_loader: turns a valid/ready word stream into accelerator load-bus writes.
// Each word is scattered into the staging register through wrd_addr. Weight targets
// then commit every staged row to memory with a single mem_en/mem_wr strobe.
module acc_stream_loader #(
  parameter int DATA_WIDTH  = 4,
  parameter int MAX_ADDR_W  = 16,
  parameter int WORD_ADDR_W = 12,
  parameter int X_SEL       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [2:0]             cfg_sel,
  input  logic [WORD_ADDR_W-1:0] cfg_words,
  input  logic [MAX_ADDR_W-1:0]  cfg_rows,
  input  logic [MAX_ADDR_W-1:0]  cfg_base,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   s_ready,
  output logic [DATA_WIDTH-1:0]  data_in,
  output logic [WORD_ADDR_W-1:0] wrd_addr,
  output logic [2:0]             mem_sel,
  output logic [MAX_ADDR_W-1:0]  mem_addr,
  output logic                   mem_en,
  output logic                   mem_wr,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [2:0] X_CODE = 3'(X_SEL);

  typedef enum logic [2:0] {IDLE, FILL, SETTLE, COMMIT, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [2:0]             sel_q;
  logic [WORD_ADDR_W-1:0] words_q;
  logic [MAX_ADDR_W-1:0]  rows_q;
  logic [WORD_ADDR_W-1:0] word_cnt;
  logic [MAX_ADDR_W-1:0]  row_cnt;
  logic                   accept;
  logic                   last_word;
  logic                   last_row;
  logic                   bad_cfg;

  assign s_ready   = (state == FILL);
  assign accept    = s_ready && s_valid;
  assign last_word = (word_cnt == (words_q - WORD_ADDR_W'(1)));
  assign last_row  = ((row_cnt + MAX_ADDR_W'(1)) == rows_q);
  assign bad_cfg   = (cfg_words == '0) || ((cfg_rows == '0) && (cfg_sel != X_CODE));

  // Next-state decision for the load sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = bad_cfg ? DONE : FILL;
      FILL:    if (accept && last_word) state_nxt = SETTLE;
      SETTLE:  state_nxt = (sel_q == X_CODE) ? DONE : COMMIT;
      COMMIT:  state_nxt = last_row ? DONE : FILL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Registered bus outputs, job configuration and counters; wrd_addr parks unless a word lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_in  <= '0;
      wrd_addr <= '1;
      mem_sel  <= '0;
      mem_addr <= '0;
      mem_en   <= 1'b0;
      mem_wr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sel_q    <= '0;
      words_q  <= '0;
      rows_q   <= '0;
      word_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      wrd_addr <= '1;
      mem_en   <= (state_nxt == COMMIT);
      mem_wr   <= (state_nxt == COMMIT);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (cfg_start) begin
            sel_q    <= cfg_sel;
            words_q  <= cfg_words;
            rows_q   <= cfg_rows;
            mem_sel  <= cfg_sel;
            mem_addr <= cfg_base;
            err      <= bad_cfg;
            word_cnt <= '0;
            row_cnt  <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            data_in  <= s_data;
            wrd_addr <= word_cnt;
            word_cnt <= last_word ? '0 : word_cnt + WORD_ADDR_W'(1);
          end
        end
        COMMIT: begin
          mem_addr <= mem_addr + MAX_ADDR_W'(1);
          row_cnt  <= row_cnt + MAX_ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
